mips32_pipeline: RTL and testbench

- 5-stage in-order MIPS32-subset integer core: IF, ID, EX, MEM, WB.
- Self-contained: 32x32 register file and unified 1024-word instruction/data memory, both internal.
- Runs on one clock. The testbench preloads programs and data by backdoor writes into the internal arrays, then releases reset.
- Top-level processing element. No external bus.

---
 rtl/mips32_pipeline.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mips32_pipeline.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_pipeline.sv
// mips32_pipeline: 5-stage MIPS32-subset core, internal regfile and memory.
// Define MIPS32_STATS_EN to add retired_cnt / cycle_cnt outputs.
package mips32_pkg;
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        wr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] sdata;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic        wr;
    logic [31:0] val;
  } mem_wb_t;
endpackage

module mips32_pipeline
  import mips32_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        halted,
  output logic [31:0] pc
`ifdef MIPS32_STATS_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
`endif
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic        hlt_seen;

  if_id_t  ifid;
  id_ex_t  idex, idex_nx;
  ex_mem_t exmem, exmem_nx;
  mem_wb_t memwb, memwb_nx;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_rtype, id_iwr, id_br, id_hlt;
  logic        id_use_rs, id_use_rt;
  logic        wb_we, ld_use, fetch_stop;
  logic [31:0] id_a, id_b;
  logic [31:0] ex_a, ex_b, ex_alu, mem_val, br_target;

  assign id_op     = ifid.ir[31:26];
  assign id_rs     = ifid.ir[25:21];
  assign id_rt     = ifid.ir[20:16];
  assign id_rd     = ifid.ir[15:11];
  assign id_rtype  = id_op <= OP_MUL;
  assign id_iwr    = id_op inside {OP_LW, OP_ADDI,
                                   OP_SUBI, OP_SLTI};
  assign id_br     = id_op inside {OP_BNEQZ, OP_BEQZ};
  assign id_hlt    = ifid.valid && id_op == OP_HLT;
  assign id_use_rs = id_rtype | id_iwr | id_br
                   | (id_op == OP_SW);
  assign id_use_rt = id_rtype | (id_op == OP_SW);

  assign wb_we = memwb.valid && memwb.wr
              && memwb.dest != 5'd0 && !HALTED;

  // Register read with write-through of the WB result
  assign id_a = (id_rs == 5'd0) ? 32'd0
              : (wb_we && memwb.dest == id_rs) ? memwb.val
              : Reg[id_rs];
  assign id_b = (id_rt == 5'd0) ? 32'd0
              : (wb_we && memwb.dest == id_rt) ? memwb.val
              : Reg[id_rt];

  assign ld_use = ifid.valid && idex.valid
               && idex.op == OP_LW && idex.dest != 5'd0
               && ((id_use_rs && id_rs == idex.dest)
                || (id_use_rt && id_rt == idex.dest));

  assign fetch_stop = hlt_seen || id_hlt || HALTED;

  always_comb begin
    idex_nx       = '0;
    idex_nx.valid = ifid.valid;
    idex_nx.pc    = ifid.pc;
    idex_nx.op    = id_op;
    idex_nx.rs    = id_rs;
    idex_nx.rt    = id_rt;
    idex_nx.dest  = id_rtype ? id_rd : id_rt;
    idex_nx.wr    = id_rtype | id_iwr;
    idex_nx.a     = id_a;
    idex_nx.b     = id_b;
    idex_nx.imm   = {{16{ifid.ir[15]}}, ifid.ir[15:0]};
  end

  assign mem_val = (exmem.op == OP_LW)
                 ? Mem[exmem.alu[AW-1:0]] : exmem.alu;

  always_comb begin
    ex_a = idex.a;
    ex_b = idex.b;
    if (exmem.valid && exmem.wr && exmem.dest != 5'd0
        && exmem.dest == idex.rs)
      ex_a = mem_val;
    else if (memwb.valid && memwb.wr && memwb.dest != 5'd0
             && memwb.dest == idex.rs)
      ex_a = memwb.val;
    if (exmem.valid && exmem.wr && exmem.dest != 5'd0
        && exmem.dest == idex.rt)
      ex_b = mem_val;
    else if (memwb.valid && memwb.wr && memwb.dest != 5'd0
             && memwb.dest == idex.rt)
      ex_b = memwb.val;
  end

  always_comb begin
    ex_alu = 32'd0;
    case (idex.op)
      OP_ADD:  ex_alu = ex_a + ex_b;
      OP_SUB:  ex_alu = ex_a - ex_b;
      OP_AND:  ex_alu = ex_a & ex_b;
      OP_OR:   ex_alu = ex_a | ex_b;
      OP_SLT:  ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:  ex_alu = ex_a * ex_b;
      OP_LW,
      OP_SW,
      OP_ADDI: ex_alu = ex_a + idex.imm;
      OP_SUBI: ex_alu = ex_a - idex.imm;
      OP_SLTI: ex_alu = {31'd0,
                         $signed(ex_a) < $signed(idex.imm)};
      default: ex_alu = 32'd0;
    endcase
  end

  assign TAKEN_BRANCH = idex.valid
    && ((idex.op == OP_BNEQZ && ex_a != 32'd0)
     || (idex.op == OP_BEQZ && ex_a == 32'd0));
  assign br_target = idex.pc + 32'd1 + idex.imm;

  always_comb begin
    exmem_nx       = '0;
    exmem_nx.valid = idex.valid;
    exmem_nx.op    = idex.op;
    exmem_nx.dest  = idex.dest;
    exmem_nx.wr    = idex.wr;
    exmem_nx.alu   = ex_alu;
    exmem_nx.sdata = ex_b;
  end

  always_comb begin
    memwb_nx       = '0;
    memwb_nx.valid = exmem.valid;
    memwb_nx.op    = exmem.op;
    memwb_nx.dest  = exmem.dest;
    memwb_nx.wr    = exmem.wr;
    memwb_nx.val   = mem_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC          <= RESET_PC;
      HALTED      <= 1'b0;
      hlt_seen    <= 1'b0;
      ifid.valid  <= 1'b0;
      idex.valid  <= 1'b0;
      exmem.valid <= 1'b0;
      memwb.valid <= 1'b0;
    end else begin
      exmem <= exmem_nx;
      memwb <= memwb_nx;
      if (memwb.valid && memwb.op == OP_HLT)
        HALTED <= 1'b1;
      // Squash beats load-use stall
      if (TAKEN_BRANCH) begin
        PC         <= br_target;
        ifid.valid <= 1'b0;
        idex.valid <= 1'b0;
      end else if (ld_use) begin
        idex.valid <= 1'b0;
      end else begin
        idex <= idex_nx;
        if (id_hlt)
          hlt_seen <= 1'b1;
        if (fetch_stop) begin
          ifid.valid <= 1'b0;
        end else begin
          ifid <= '{valid: 1'b1, pc: PC,
                    ir: Mem[PC[AW-1:0]]};
          PC   <= PC + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !HALTED && exmem.valid
        && exmem.op == OP_SW)
      Mem[exmem.alu[AW-1:0]] <= exmem.sdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && wb_we)
      Reg[memwb.dest] <= memwb.val;
  end

`ifdef MIPS32_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= 32'd0;
      cycle_cnt   <= 32'd0;
    end else if (!HALTED) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (memwb.valid)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

  assign halted = HALTED;
  assign pc     = PC;
endmodule

// File: tb/tb_mips32_pipeline.sv
// tb_mips32_pipeline: directed and random programs checked
// against an instruction-level reference interpreter.
module tb_mips32_pipeline;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [31:0] pc;
`ifdef MIPS32_STATS_EN
  logic [31:0] retired_cnt;
  logic [31:0] cycle_cnt;
`endif

  mips32_pipeline dut (
    .clk(clk),
    .rst(rst),
    .halted(halted),
    .pc(pc)
`ifdef MIPS32_STATS_EN
    ,
    .retired_cnt(retired_cnt),
    .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [1024];
  logic [31:0] prog  [$];

  function automatic logic [31:0] enc_r(
    input int op, input int rd, input int rs, input int rt);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(
    input int op, input int rt, input int rs, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  localparam logic [31:0] HLT = {6'h3f, 26'd0};

  task automatic poke_reg(input int k, input logic [31:0] v);
    dut.Reg[k] <= v;
    m_reg[k] = v;
  endtask

  task automatic poke_mem(input int a, input logic [31:0] v);
    dut.Mem[a] <= v;
    m_mem[a] = v;
  endtask

  task automatic begin_test();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1024; i++) poke_mem(i, 32'd0);
    for (int k = 0; k < 32; k++) poke_reg(k, 32'd0);
    prog.delete();
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) poke_mem(i, prog[i]);
  endtask

  task automatic run(input int budget, output bit ok);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Sequential ISA interpreter: one instruction per step
  task automatic model_exec();
    int unsigned p;
    logic [31:0] ir, a, b, imm;
    int rs, rt, rd;
    p = 0;
    for (int s = 0; s < 20000; s++) begin
      ir  = m_mem[p % 1024];
      rs  = int'(ir[25:21]);
      rt  = int'(ir[20:16]);
      rd  = int'(ir[15:11]);
      a   = m_reg[rs];
      b   = m_reg[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      p   = p + 1;
      case (ir[31:26])
        6'd0:  m_reg[rd] = a + b;
        6'd1:  m_reg[rd] = a - b;
        6'd2:  m_reg[rd] = a & b;
        6'd3:  m_reg[rd] = a | b;
        6'd4:  m_reg[rd] = ($signed(a) < $signed(b)) ? 1 : 0;
        6'd5:  m_reg[rd] = a * b;
        6'd8:  m_reg[rt] = m_mem[(a + imm) & 32'd1023];
        6'd9:  m_mem[(a + imm) & 32'd1023] = b;
        6'd10: m_reg[rt] = a + imm;
        6'd11: m_reg[rt] = a - imm;
        6'd12: m_reg[rt] = ($signed(a) < $signed(imm)) ? 1 : 0;
        6'd13: if (a != 0) p = p + imm;
        6'd14: if (a == 0) p = p + imm;
        6'd63: return;
        default: ;
      endcase
      m_reg[0] = 32'd0;
    end
  endtask

  task automatic test_reset();
    begin_test();
    for (int k = 1; k < 32; k++) poke_reg(k, k);
    @(negedge clk);
    n_checks++;
    if (pc !== 32'd0)
      $display("FAIL reset_pc: got %0h want 0", pc);
    else n_pass++;
    n_checks++;
    if (halted !== 1'b0)
      $display("FAIL reset_halted: got %b want 0", halted);
    else n_pass++;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pc !== 32'd0)
      $display("FAIL rerun_reset_pc: got %0h want 0", pc);
    else n_pass++;
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (dut.Reg[k] !== 32'(k))
        $display("FAIL reset_reg%0d: got %0h want %0h",
                 k, dut.Reg[k], k);
      else n_pass++;
    end
  endtask

  task automatic test_factorial();
    logic [31:0] seen [$];
    logic [31:0] want [5];
    logic [31:0] last;
    bit ok;
    want = '{32'd1, 32'd5, 32'd20, 32'd60, 32'd120};
    begin_test();
    prog.push_back(enc_i(10, 10, 0, 200));
    prog.push_back(enc_i(10, 2, 0, 1));
    prog.push_back(enc_i(8, 3, 10, 0));
    prog.push_back(enc_r(5, 2, 2, 3));
    prog.push_back(enc_i(11, 3, 3, 1));
    prog.push_back(enc_i(13, 0, 3, -3));
    prog.push_back(enc_i(9, 2, 10, -2));
    prog.push_back(HLT);
    load_prog();
    poke_mem(200, 32'd5);
    @(negedge clk);
    rst = 1'b0;
    last = 32'd0;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (dut.Reg[2] !== last) begin
        last = dut.Reg[2];
        seen.push_back(last);
      end
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) $display("FAIL fact_timeout: halted=%b want 1", halted);
    else n_pass++;
    n_checks++;
    if (seen.size() != 5)
      $display("FAIL fact_r2_count: got %0d want 5", seen.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      n_checks++;
      if (seen[i] !== want[i])
        $display("FAIL fact_r2_%0d: got %0d want %0d",
                 i, seen[i], want[i]);
      else n_pass++;
    end
    n_checks++;
    if (dut.Mem[198] !== 32'd120)
      $display("FAIL fact_mem198: got %0d want 120", dut.Mem[198]);
    else n_pass++;
    n_checks++;
    if (dut.Mem[200] !== 32'd5)
      $display("FAIL fact_mem200: got %0d want 5", dut.Mem[200]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    begin_test();
    prog.push_back(enc_i(8, 1, 0, 100));
    prog.push_back(enc_r(0, 2, 1, 1));
    prog.push_back(enc_r(1, 3, 2, 1));
    prog.push_back(HLT);
    load_prog();
    poke_mem(100, 32'd7);
    run(200, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_timeout: halted=%b want 1", halted);
    else n_pass++;
    n_checks++;
    if (dut.Reg[2] !== 32'd14)
      $display("FAIL b2b_r2: got %0d want 14", dut.Reg[2]);
    else n_pass++;
    n_checks++;
    if (dut.Reg[3] !== 32'd7)
      $display("FAIL b2b_r3: got %0d want 7", dut.Reg[3]);
    else n_pass++;
  endtask

  task automatic test_alu_corners();
    bit ok;
    logic [31:0] want [10];
    want = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1,
             32'd5, 32'd0, 32'h10000, 32'd0, 32'd0};
    begin_test();
    for (int k = 3; k < 10; k++) poke_reg(k, 32'hDEADBEEF);
    prog.push_back(enc_i(10, 1, 0, -1));
    prog.push_back(enc_i(10, 2, 0, 1));
    prog.push_back(enc_r(0, 3, 1, 2));
    prog.push_back(enc_r(4, 4, 1, 2));
    prog.push_back(enc_i(10, 5, 0, 5));
    prog.push_back(enc_i(12, 6, 5, -3));
    prog.push_back(enc_i(10, 7, 0, 256));
    prog.push_back(enc_r(5, 7, 7, 7));
    prog.push_back(enc_r(5, 8, 7, 7));
    prog.push_back(enc_i(10, 0, 0, 5));
    prog.push_back(enc_r(0, 9, 0, 0));
    prog.push_back(HLT);
    load_prog();
    run(200, ok);
    n_checks++;
    if (!ok) $display("FAIL alu_timeout: halted=%b want 1", halted);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (dut.Reg[k] !== want[k])
        $display("FAIL alu_r%0d: got %0h want %0h",
                 k, dut.Reg[k], want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_branches();
    bit ok;
    begin_test();
    poke_reg(5, 32'h55);
    prog.push_back(enc_i(10, 1, 0, 3));
    prog.push_back(enc_i(14, 0, 1, 2));
    prog.push_back(enc_i(10, 4, 0, 4));
    prog.push_back(enc_i(13, 0, 1, 1));
    prog.push_back(enc_i(10, 5, 0, 9));
    prog.push_back(enc_i(13, 0, 1, 1));
    prog.push_back(HLT);
    prog.push_back(enc_i(10, 6, 0, 6));
    prog.push_back(HLT);
    load_prog();
    run(200, ok);
    n_checks++;
    if (!ok) $display("FAIL br_timeout: halted=%b want 1", halted);
    else n_pass++;
    n_checks++;
    if (dut.Reg[4] !== 32'd4)
      $display("FAIL br_fallthru_r4: got %0h want 4", dut.Reg[4]);
    else n_pass++;
    n_checks++;
    if (dut.Reg[5] !== 32'h55)
      $display("FAIL br_squash_r5: got %0h want 55", dut.Reg[5]);
    else n_pass++;
    n_checks++;
    if (dut.Reg[6] !== 32'd6)
      $display("FAIL br_hlt_squash_r6: got %0h want 6", dut.Reg[6]);
    else n_pass++;
  endtask

  task automatic test_hlt();
    bit ok;
    logic [31:0] pc0;
    begin_test();
    poke_reg(2, 32'h22);
    prog.push_back(enc_i(10, 1, 0, 77));
    prog.push_back(HLT);
    prog.push_back(enc_i(9, 1, 0, 50));
    prog.push_back(enc_i(10, 2, 0, 5));
    load_prog();
    poke_mem(50, 32'h1234);
    run(200, ok);
    n_checks++;
    if (!ok) $display("FAIL hlt_timeout: halted=%b want 1", halted);
    else n_pass++;
    pc0 = pc;
    n_checks++;
    if (pc0 !== 32'd2)
      $display("FAIL hlt_pc: got %0h want 2", pc0);
    else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (pc !== pc0)
      $display("FAIL hlt_pc_frozen: got %0h want %0h", pc, pc0);
    else n_pass++;
    n_checks++;
    if (halted !== 1'b1)
      $display("FAIL hlt_sticky: got %b want 1", halted);
    else n_pass++;
    n_checks++;
    if (dut.Mem[50] !== 32'h1234)
      $display("FAIL hlt_mem50: got %0h want 1234", dut.Mem[50]);
    else n_pass++;
    n_checks++;
    if (dut.Reg[2] !== 32'h22)
      $display("FAIL hlt_r2: got %0h want 22", dut.Reg[2]);
    else n_pass++;
    n_checks++;
    if (dut.Reg[1] !== 32'd77)
      $display("FAIL hlt_r1: got %0h want 4d", dut.Reg[1]);
    else n_pass++;
`ifdef MIPS32_STATS_EN
    n_checks++;
    if (retired_cnt !== 32'd2)
      $display("FAIL hlt_retired: got %0d want 2", retired_cnt);
    else n_pass++;
`endif
  endtask

  function automatic logic [31:0] rand_instr();
    int k, d, s, t;
    k = $urandom_range(0, 14);
    d = $urandom_range(1, 7);
    s = $urandom_range(0, 7);
    t = $urandom_range(0, 7);
    case (k)
      0, 1, 2, 3, 4, 5: return enc_r(k, d, s, t);
      6:  return enc_i(8, d, 0, $urandom_range(300, 315));
      7:  return enc_i(9, t, 0, $urandom_range(300, 315));
      8:  return enc_i(10, d, s, $urandom_range(0, 65535));
      9:  return enc_i(11, d, s, $urandom_range(0, 65535));
      10: return enc_i(12, d, s, $urandom_range(0, 65535));
      11: return enc_i(13, 0, s, $urandom_range(0, 3));
      12: return enc_i(14, 0, s, $urandom_range(0, 3));
      13: return {6'($urandom_range(16, 62)), 26'($urandom)};
      default: return enc_r(0, d, d, d);
    endcase
  endfunction

  task automatic test_random();
    bit ok;
    for (int n = 0; n < 8; n++) begin
      begin_test();
      for (int k = 1; k < 32; k++)
        poke_reg(k, (k & 1) ? 32'($urandom) : 32'($urandom_range(0, 9)));
      for (int i = 0; i < 24; i++) prog.push_back(rand_instr());
      for (int i = 0; i < 5; i++) prog.push_back(HLT);
      load_prog();
      for (int a = 300; a < 316; a++) poke_mem(a, 32'($urandom));
      model_exec();
      run(1000, ok);
      n_checks++;
      if (!ok) $display("FAIL rnd%0d_timeout: halted=%b want 1", n, halted);
      else n_pass++;
      for (int k = 0; k < 32; k++) begin
        n_checks++;
        if (dut.Reg[k] !== m_reg[k])
          $display("FAIL rnd%0d_r%0d: got %0h want %0h",
                   n, k, dut.Reg[k], m_reg[k]);
        else n_pass++;
      end
      for (int a = 300; a < 316; a++) begin
        n_checks++;
        if (dut.Mem[a] !== m_mem[a])
          $display("FAIL rnd%0d_mem%0d: got %0h want %0h",
                   n, a, dut.Mem[a], m_mem[a]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_factorial();
    test_back_to_back();
    test_alu_corners();
    test_branches();
    test_hlt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
